// File: rtl/rf_pkg.sv
// rf_pkg: shared definitions for the multi-port register file.
//   rf_state_t : sweep controller state encoding (CLEAR=0, READY=1)
//   calc_aw    : selector width for a given register count, never below 1
package rf_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } rf_state_t;

    function automatic int calc_aw(input int depth);
        int aw;
        aw = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < depth) begin
                aw = i + 1;
            end
        end
        return aw;
    endfunction

endpackage

// File: rtl/rf_multiport_if.sv
// rf_multiport_if: bus between a client and the register file.
//   rd_sel  [NREAD*AW]    read selectors, port i at [i*AW +: AW]
//   rd_data [NREAD*WIDTH] registered read data, port i at [i*WIDTH +: WIDTH]
//   wr_en / wr_sel / wr_data  single write port
//   clear   request a full zero sweep
//   ready   file accepts writes
//   err     one-cycle pulse for any dropped write or bad read selector
interface rf_multiport_if import rf_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int NREAD = 2
) ();

    localparam int AW = calc_aw(DEPTH);

    logic [NREAD*AW-1:0]    rd_sel;
    logic [NREAD*WIDTH-1:0] rd_data;
    logic                   wr_en;
    logic [AW-1:0]          wr_sel;
    logic [WIDTH-1:0]       wr_data;
    logic                   clear;
    logic                   ready;
    logic                   err;

    modport master (
        output rd_sel, wr_en, wr_sel, wr_data, clear,
        input  rd_data, ready, err
    );

    modport slave (
        input  rd_sel, wr_en, wr_sel, wr_data, clear,
        output rd_data, ready, err
    );

endinterface

// File: rtl/rf_clear_ctl.sv
// rf_clear_ctl: sweep FSM and write arbitration for the register file.
//   clk, rst_n          clock, synchronous active-low reset
//   clear               restart the zero sweep
//   wr_en, wr_sel       client write request
//   ready               registered, high while writes are accepted
//   sweeping            high while the FSM is in CLEAR
//   mem_we, mem_addr    storage write strobe/address (sweep or client)
//   wr_accept           client write lands this cycle (used for read bypass)
//   wr_err              client write dropped with an error
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   ST_CLEAR | zero entry cnt each cycle; writes dropped, reads zero
//   ST_READY | normal operation; writes and reads serviced
module rf_clear_ctl import rf_pkg::*; #(
    parameter int DEPTH    = 8,
    parameter int ZERO_REG = 0,
    parameter int AW       = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_sel,
    output logic          ready,
    output logic          sweeping,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic          wr_accept,
    output logic          wr_err
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    rf_state_t     state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic          sel_ok;
    logic          sel_zero_drop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ready <= (state_nxt == ST_READY);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_CLEAR: begin
                if (clear) begin
                    cnt_nxt = '0;
                end else if (cnt == LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_READY;
                end else begin
                    cnt_nxt = cnt + AW'(1);
                end
            end
            ST_READY: begin
                if (clear) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_CLEAR;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = ST_CLEAR;
            end
        endcase
    end

    // Writes to entry 0 with ZERO_REG are dropped without raising err.
    assign sel_ok        = int'(wr_sel) < DEPTH;
    assign sel_zero_drop = (ZERO_REG != 0) && (wr_sel == '0);

    always_comb begin
        sweeping  = (state == ST_CLEAR);
        wr_accept = wr_en && (state == ST_READY) && !clear && sel_ok && !sel_zero_drop;
        wr_err    = wr_en && ((state != ST_READY) || clear || !sel_ok);
        mem_we    = sweeping || wr_accept;
        mem_addr  = sweeping ? cnt : wr_sel;
    end

endmodule

// File: rtl/rf_multiport.sv
// rf_multiport: register file with one write port and NREAD registered
// read ports, zeroed by a DEPTH-cycle sweep after reset or on clear.
//   clk, rst_n  clock, synchronous active-low reset
//   bus         rf_multiport_if slave (see interface for signal list)
module rf_multiport import rf_pkg::*; #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    rf_multiport_if.slave bus
);

    localparam int AW = calc_aw(DEPTH);

    logic                   ready;
    logic                   sweeping;
    logic                   mem_we;
    logic [AW-1:0]          mem_addr;
    logic                   wr_accept;
    logic                   wr_err;
    logic [NREAD-1:0]       rd_bad;
    logic [NREAD*WIDTH-1:0] rd_flat;
    logic                   err_q;
    logic [WIDTH-1:0]       mem [DEPTH];

    rf_clear_ctl #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_ctl (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (bus.clear),
        .wr_en     (bus.wr_en),
        .wr_sel    (bus.wr_sel),
        .ready     (ready),
        .sweeping  (sweeping),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .wr_accept (wr_accept),
        .wr_err    (wr_err)
    );

    // Storage is not reset; the sweep zeroes it before READY.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= sweeping ? '0 : bus.wr_data;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0]    sel;
        logic             sel_bad;
        logic             force_zero;
        logic [WIDTH-1:0] rd_q;

        assign sel        = bus.rd_sel[i*AW +: AW];
        assign sel_bad    = int'(sel) >= DEPTH;
        // ZERO_REG entry 0 beats bypass: wr_accept is never set for it anyway,
        // but this keeps the read path independent of that.
        assign force_zero = sweeping || sel_bad || ((ZERO_REG != 0) && (sel == '0));

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rd_q <= '0;
            end else if (force_zero) begin
                rd_q <= '0;
            end else if (wr_accept && (bus.wr_sel == sel)) begin
                rd_q <= bus.wr_data;
            end else begin
                rd_q <= mem[sel];
            end
        end

        assign rd_flat[i*WIDTH +: WIDTH] = rd_q;
        assign rd_bad[i]                 = sel_bad;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= wr_err || (|rd_bad);
        end
    end

    assign bus.rd_data = rd_flat;
    assign bus.ready   = ready;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_rf_multiport.sv
module tb_rf_multiport;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic        clear;
    logic [2:0]  wr_sel;
    logic [15:0] wr_data;
    logic [5:0]  rd_sel;

    int total = 0;
    int bad   = 0;

    // Three instances share one stimulus: defaults, DEPTH=6, ZERO_REG=1.
    rf_multiport_if #(.WIDTH(16), .DEPTH(8), .NREAD(2)) if_def ();
    rf_multiport_if #(.WIDTH(16), .DEPTH(6), .NREAD(2)) if_d6 ();
    rf_multiport_if #(.WIDTH(16), .DEPTH(8), .NREAD(2)) if_z ();

    rf_multiport #(.WIDTH(16), .DEPTH(8), .NREAD(2), .ZERO_REG(0)) u_def (.clk(clk), .rst_n(rst_n), .bus(if_def));
    rf_multiport #(.WIDTH(16), .DEPTH(6), .NREAD(2), .ZERO_REG(0)) u_d6  (.clk(clk), .rst_n(rst_n), .bus(if_d6));
    rf_multiport #(.WIDTH(16), .DEPTH(8), .NREAD(2), .ZERO_REG(1)) u_z   (.clk(clk), .rst_n(rst_n), .bus(if_z));

    assign if_def.rd_sel  = rd_sel;  assign if_d6.rd_sel  = rd_sel;  assign if_z.rd_sel  = rd_sel;
    assign if_def.wr_en   = wr_en;   assign if_d6.wr_en   = wr_en;   assign if_z.wr_en   = wr_en;
    assign if_def.wr_sel  = wr_sel;  assign if_d6.wr_sel  = wr_sel;  assign if_z.wr_sel  = wr_sel;
    assign if_def.wr_data = wr_data; assign if_d6.wr_data = wr_data; assign if_z.wr_data = wr_data;
    assign if_def.clear   = clear;   assign if_d6.clear   = clear;   assign if_z.clear   = clear;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Contents are invisible while clearing, so the model simply wipes its
    // array when a sweep starts and counts down the cycles left until ready.
    logic [15:0] m_mem [3][8];
    logic [15:0] m_rd  [3][2];
    bit          m_rdy [3];
    bit          m_err [3];
    int          m_left[3];
    bit          m_valid = 1'b0;

    function automatic int dep_of(input int k);
        return (k == 1) ? 6 : 8;
    endfunction

    function automatic bit zr_of(input int k);
        return (k == 2);
    endfunction

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int d;
            bit z, acc, e, rdy_now;
            d = dep_of(k);
            z = zr_of(k);
            if (!rst_n) begin
                m_rdy[k]  = 1'b0;
                m_err[k]  = 1'b0;
                m_left[k] = d;
                for (int i = 0; i < 2; i++) m_rd[k][i] = '0;
                for (int j = 0; j < 8; j++) m_mem[k][j] = '0;
            end else begin
                rdy_now = m_rdy[k];
                e = wr_en && (!rdy_now || clear || int'(wr_sel) >= d);
                acc = wr_en && rdy_now && !clear && int'(wr_sel) < d && !(z && wr_sel == 0);
                for (int i = 0; i < 2; i++) begin
                    int s;
                    s = int'(rd_sel[i*3 +: 3]);
                    if (s >= d) e = 1'b1;
                    if (!rdy_now || s >= d || (z && s == 0)) m_rd[k][i] = '0;
                    else if (acc && int'(wr_sel) == s)      m_rd[k][i] = wr_data;
                    else                                    m_rd[k][i] = m_mem[k][s];
                end
                if (acc) m_mem[k][wr_sel] = wr_data;
                if (!rdy_now) begin
                    if (clear) m_left[k] = d;
                    else begin
                        m_left[k] = m_left[k] - 1;
                        if (m_left[k] == 0) m_rdy[k] = 1'b1;
                    end
                end else if (clear) begin
                    m_rdy[k]  = 1'b0;
                    m_left[k] = d;
                    for (int j = 0; j < 8; j++) m_mem[k][j] = '0;
                end
                m_err[k] = e;
            end
        end
        if (!rst_n) m_valid = 1'b1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- checking ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input string nm, input int k, input logic [31:0] rd, input logic rdy, input logic er);
        check({nm, ".rd_data"}, rd, {16'h0, m_rd[k][1], m_rd[k][0]});
        check({nm, ".ready"}, {31'h0, rdy}, {31'h0, m_rdy[k]});
        check({nm, ".err"}, {31'h0, er}, {31'h0, m_err[k]});
    endtask

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            cmp_inst("def", 0, {16'h0, if_def.rd_data}, if_def.ready, if_def.err);
            cmp_inst("d6",  1, {16'h0, if_d6.rd_data},  if_d6.ready,  if_d6.err);
            cmp_inst("z",   2, {16'h0, if_z.rd_data},   if_z.ready,   if_z.err);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        clear   = 1'b0;
        wr_sel  = '0;
        wr_data = '0;
        rd_sel  = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        step();
        step();
        check("reset.ready", {31'h0, if_def.ready}, 32'h0);
        check("reset.err", {31'h0, if_def.err}, 32'h0);
        check("reset.rd_data", {16'h0, if_def.rd_data}, 32'h0);

        // Sweep after reset: 8 cycles at DEPTH=8, 6 cycles at DEPTH=6.
        rst_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            check($sformatf("sweep.def.ready.c%0d", c), {31'h0, if_def.ready}, (c == 8) ? 32'h1 : 32'h0);
            if (c == 5 || c == 6)
                check($sformatf("sweep.d6.ready.c%0d", c), {31'h0, if_d6.ready}, (c == 6) ? 32'h1 : 32'h0);
        end
        for (int e = 0; e < 8; e++) begin
            rd_sel = {3'(7 - e), 3'(e)};
            step();
            check($sformatf("zero.rd.e%0d", e), {16'h0, if_def.rd_data}, 32'h0);
        end

        // Write/read same entry on both ports: bypass, then stored value.
        wr_en = 1'b1; wr_sel = 3'd3; wr_data = 16'hBEEF; rd_sel = {3'd3, 3'd3};
        step();
        check("bypass.rd", {16'h0, if_def.rd_data}, 32'hBEEF_BEEF);
        wr_en = 1'b0;
        step();
        check("bypass.hold", {16'h0, if_def.rd_data}, 32'hBEEF_BEEF);

        // Out-of-range write and read on the DEPTH=6 instance.
        wr_en = 1'b1; wr_sel = 3'd7; wr_data = 16'hDEAD; rd_sel = {3'd6, 3'd6};
        step();
        check("oor.err", {31'h0, if_d6.err}, 32'h1);
        check("oor.rd", {16'h0, if_d6.rd_data}, 32'h0);
        idle();
        step();
        check("oor.err_pulse", {31'h0, if_d6.err}, 32'h0);
        for (int e = 0; e < 6; e++) begin
            rd_sel = {3'd0, 3'(e)};
            step();
            check($sformatf("oor.keep.e%0d", e), {16'h0, if_d6.rd_data[15:0]}, (e == 3) ? 32'hBEEF : 32'h0);
        end

        // ZERO_REG entry 0: write dropped silently, reads zero even with bypass.
        wr_en = 1'b1; wr_sel = 3'd0; wr_data = 16'h1234; rd_sel = {3'd0, 3'd0};
        step();
        check("zreg.rd", {16'h0, if_z.rd_data}, 32'h0);
        check("zreg.err", {31'h0, if_z.err}, 32'h0);
        check("zreg.def_bypass", {16'h0, if_def.rd_data}, 32'h1234_1234);
        idle();

        // Fill, clear, write during sweep, then everything reads zero.
        for (int e = 0; e < 8; e++) begin
            wr_en = 1'b1; wr_sel = 3'(e); wr_data = 16'h1111 * 16'(e + 1);
            step();
        end
        idle();
        rd_sel = {3'd7, 3'd4};
        step();
        check("fill.rd", {16'h0, if_def.rd_data}, 32'h8888_5555);
        clear = 1'b1;
        step();
        check("clr.ready.c0", {31'h0, if_def.ready}, 32'h0);
        clear = 1'b0; wr_en = 1'b1; wr_sel = 3'd2; wr_data = 16'h5555;
        step();
        check("clr.write_err", {31'h0, if_def.err}, 32'h1);
        wr_en = 1'b0;
        for (int c = 2; c <= 8; c++) begin
            step();
            check($sformatf("clr.ready.c%0d", c), {31'h0, if_def.ready}, (c == 8) ? 32'h1 : 32'h0);
        end
        for (int e = 0; e < 8; e++) begin
            rd_sel = {3'(e), 3'(e)};
            step();
            check($sformatf("clr.rd.e%0d", e), {16'h0, if_def.rd_data}, 32'h0);
        end
        idle();

        // Reset during the sweep restarts it.
        clear = 1'b1;
        step();
        clear = 1'b0;
        step(); step(); step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            check($sformatf("rst_mid.ready.c%0d", c), {31'h0, if_def.ready}, (c == 8) ? 32'h1 : 32'h0);
        end

        // Randomized traffic, checked every cycle by the compare process.
        for (int n = 0; n < 600; n++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_sel  = 3'($urandom_range(0, 7));
            wr_data = 16'($urandom);
            rd_sel  = 6'($urandom);
            clear   = ($urandom_range(0, 49) == 0);
            rst_n   = !($urandom_range(0, 149) == 0);
            step();
        end
        rst_n = 1'b1;
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
